instr_fetch_queue: RTL

Instruction prefetch queue between the instruction memory and the IF/ID pipeline register. It issues sequential fetch requests to a variable-latency instruction memory and buffers up to DEPTH returned {pc, instr} pairs. It presents the oldest pair to the decode stage, which consumes it with deq_i and can stall by holding deq_i low. A redirect from the MEM stage (taken branch) flushes the queue and discards any in-flight response.

---
 rtl/instr_fetch_queue.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches and buffers {pc, instr} pairs.
// Latency: request 1 cycle after issue decision; valid_o 1 cycle after ack (same cycle with FETCH_QUEUE_BYPASS_EN).
// Backpressure: decode stalls by holding deq_i low; no request is issued once the queue would fill.
module instr_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   output logic                       imem_req_o,
   output logic [31:0]                imem_addr_o,
   input  logic                       imem_ack_i,
   input  logic [31:0]                imem_instr_i,
   input  logic                       redirect_i,
   input  logic [31:0]                redirect_pc_i,
   input  logic                       deq_i,
   output logic                       valid_o,
   output logic [31:0]                instr_o,
   output logic [31:0]                pc_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

   state_t          state_q, state_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic            req_q, req_d;
   logic [31:0]     addr_q, addr_d;
   logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     pc_mem_q    [DEPTH];
   logic [31:0]     instr_mem_q [DEPTH];

   logic            ack_wait;   // response for a live request arrives this cycle
   logic            cont;       // enough room to keep fetching after this response
   logic            issue;
   logic            push;
   logic            pop;
   logic            bypass;

   assign ack_wait = (state_q == S_WAIT) && imem_ack_i && !redirect_i;
   // Same-cycle dequeue is deliberately not credited, so the check uses the current count.
   assign cont     = start_i && ((cnt_q + CW'(1)) < CW'(DEPTH));

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_i) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; redirect turns a live request into one whose response is dropped
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (!redirect_i && start_i && (cnt_q < CW'(DEPTH))) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (imem_ack_i) begin
               if (redirect_i || !cont) state_d = S_IDLE;
            end else if (redirect_i) begin
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (imem_ack_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output/datapath control: request issue, push/pop, pointer and pc updates
   always_comb begin
      issue = 1'b0;
      if (!redirect_i) begin
         if (state_q == S_IDLE) issue = start_i && (cnt_q < CW'(DEPTH));
         else if (ack_wait)     issue = cont;
      end

`ifdef FETCH_QUEUE_BYPASS_EN
      bypass = ack_wait && (cnt_q == '0);
      push   = ack_wait && !(bypass && deq_i);
`else
      bypass = 1'b0;
      push   = ack_wait;
`endif
      pop    = deq_i && (cnt_q != '0) && !redirect_i;

      req_d  = issue;
      addr_d = addr_q;
      if (issue) addr_d = (state_q == S_IDLE) ? fetch_pc_q : fetch_pc_q + 32'd4;

      fetch_pc_d = fetch_pc_q;
      if (redirect_i)    fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      else if (ack_wait) fetch_pc_d = fetch_pc_q + 32'd4;

      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (redirect_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) wr_d = wr_q + PW'(1);
         if (pop)  rd_d = rd_q + PW'(1);
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   // Control registers
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         fetch_pc_q <= RESET_PC;
         req_q      <= 1'b0;
         addr_q     <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
      end
   end

   // Circular entry storage; cleared on reset so the head reads zero
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else if (push) begin
         pc_mem_q[wr_q]    <= fetch_pc_q;
         instr_mem_q[wr_q] <= imem_instr_i;
      end
   end

   assign imem_req_o  = req_q;
   assign imem_addr_o = addr_q;
   assign count_o     = cnt_q;

   // Head presentation; bypass forwards the live response into an empty queue
   always_comb begin
      valid_o = (cnt_q != '0);
      instr_o = instr_mem_q[rd_q];
      pc_o    = pc_mem_q[rd_q];
      if (bypass) begin
         valid_o = 1'b1;
         instr_o = imem_instr_i;
         pc_o    = fetch_pc_q;
      end
   end

endmodule
